// File: rtl/lcd1602_driver.sv
// HD44780-style 16x2 character LCD driver in 8-bit mode: init, optional CGRAM glyph upload,
// then rewrites both lines from an internal 32-byte display buffer.
module lcd1602_driver #(
  parameter int CLK_DIV   = 50000,
  parameter int N_CGRAM   = 3,
  parameter int REFRESH   = 1,
  parameter int CLR_STEPS = 4
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       buf_we,
  input  logic [4:0] buf_addr,
  input  logic [7:0] buf_wdata,
  input  logic       cg_we,
  input  logic [5:0] cg_addr,
  input  logic [4:0] cg_wdata,
  input  logic       refresh_req,
  output logic       busy,
  output logic       en,
  output logic       RS,
  output logic       RW,
  output logic [7:0] data
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] EN_ON    = CW'(CLK_DIV / 4);
  localparam logic [CW-1:0] EN_OFF   = CW'(3 * CLK_DIV / 4);
  localparam logic [5:0]    CG_LAST  = (N_CGRAM > 0) ? 6'(8 * N_CGRAM - 1) : 6'd0;
  localparam logic [7:0]    CLR_LAST = 8'(CLR_STEPS - 1);

  typedef enum logic [3:0] {
    INIT_CLR, INIT_FUNC, INIT_DISP, INIT_ENTRY, CG_ADDR, CG_DATA,
    L1_ADDR, L1_DATA, L2_ADDR, L2_DATA, IDLE
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0]  clr_cnt, clr_n;
  logic [5:0]  idx, idx_n;
  logic [7:0]  data_n;
  logic        rs_n;
  logic        cg_dirty, refresh_pend;
  logic        cg_clr, pend_clr, cg_accept;
  logic [7:0]  disp_buf [32];
  logic [4:0]  cg_buf   [64];
  logic [4:0]  rd_addr;
  logic [7:0]  buf_byte;
  logic [4:0]  cg_row;

  assign cg_accept = cg_we && ({1'b0, cg_addr[5:3]} < 4'(N_CGRAM));
  assign rd_addr   = {state == L2_DATA, idx[3:0]};
  // Writes landing on the sampling edge are forwarded so they appear in the byte sent.
  assign buf_byte  = (buf_we && buf_addr == rd_addr) ? buf_wdata : disp_buf[rd_addr];
  assign cg_row    = (cg_accept && cg_addr == idx) ? cg_wdata : cg_buf[idx];
  assign pend_clr  = (state_n == L1_ADDR) && (state != L1_ADDR);
  assign busy      = (state != IDLE);
  assign RW        = 1'b0;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state   <= INIT_CLR;
      cnt     <= '0;
      clr_cnt <= '0;
      idx     <= '0;
      data    <= 8'h00;
      RS      <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      clr_cnt <= clr_n;
      idx     <= idx_n;
      data    <= data_n;
      RS      <= rs_n;
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) disp_buf[i] <= 8'h20;
      for (int i = 0; i < 64; i++) cg_buf[i] <= 5'h00;
      cg_dirty     <= 1'b0;
      refresh_pend <= 1'b0;
    end else begin
      if (buf_we) disp_buf[buf_addr] <= buf_wdata;
      if (cg_accept) cg_buf[cg_addr] <= cg_wdata;
      if (cg_accept) cg_dirty <= 1'b1;
      else if (cg_clr) cg_dirty <= 1'b0;
      if (refresh_req) refresh_pend <= 1'b1;
      else if (pend_clr) refresh_pend <= 1'b0;
    end
  end

  // Bytes are loaded at count 0; state advances on the last count of the step,
  // except IDLE, whose exit at count 0 also loads the first address byte.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    clr_n   = clr_cnt;
    data_n  = data;
    rs_n    = RS;
    cg_clr  = 1'b0;
    if (cnt == '0) begin
      case (state)
        INIT_CLR:   begin data_n = 8'h01; rs_n = 1'b0; end
        INIT_FUNC:  begin data_n = 8'h38; rs_n = 1'b0; end
        INIT_DISP:  begin data_n = 8'h0C; rs_n = 1'b0; end
        INIT_ENTRY: begin data_n = 8'h06; rs_n = 1'b0; end
        CG_ADDR:    begin data_n = 8'h40; rs_n = 1'b0; end
        CG_DATA:    begin data_n = {3'b000, cg_row}; rs_n = 1'b1; end
        L1_ADDR:    begin data_n = 8'h80; rs_n = 1'b0; end
        L2_ADDR:    begin data_n = 8'hC0; rs_n = 1'b0; end
        L1_DATA, L2_DATA: begin data_n = buf_byte; rs_n = 1'b1; end
        IDLE: begin
          if (cg_dirty) begin
            state_n = CG_ADDR;
            data_n  = 8'h40;
            rs_n    = 1'b0;
            cg_clr  = 1'b1;
          end else if (refresh_pend || REFRESH != 0) begin
            state_n = L1_ADDR;
            data_n  = 8'h80;
            rs_n    = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (cnt == CNT_LAST) begin
      case (state)
        INIT_CLR: begin
          if (clr_cnt == CLR_LAST) begin
            state_n = INIT_FUNC;
            clr_n   = '0;
          end else begin
            clr_n = clr_cnt + 8'd1;
          end
        end
        INIT_FUNC:  state_n = INIT_DISP;
        INIT_DISP:  state_n = INIT_ENTRY;
        INIT_ENTRY: state_n = (N_CGRAM > 0) ? CG_ADDR : L1_ADDR;
        CG_ADDR:    begin state_n = CG_DATA; idx_n = '0; end
        CG_DATA: begin
          if (idx == CG_LAST) begin state_n = L1_ADDR; idx_n = '0; end
          else idx_n = idx + 6'd1;
        end
        L1_ADDR: begin state_n = L1_DATA; idx_n = '0; end
        L1_DATA: begin
          if (idx == 6'd15) begin state_n = L2_ADDR; idx_n = '0; end
          else idx_n = idx + 6'd1;
        end
        L2_ADDR: begin state_n = L2_DATA; idx_n = '0; end
        L2_DATA: begin
          if (idx == 6'd15) begin state_n = IDLE; idx_n = '0; end
          else idx_n = idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // The clear command only strobes once; its remaining steps are settling time.
  always_comb begin
    en = 1'b0;
    if (state != IDLE && (state != INIT_CLR || clr_cnt == 8'd0) && cnt >= EN_ON && cnt < EN_OFF)
      en = 1'b1;
  end

endmodule

// File: tb/tb_lcd1602_driver.sv
// Bench for lcd1602_driver: three instances (no glyphs, three glyphs, continuous refresh)
// share stimulus; every en strobe is captured and compared with a byte-stream model.
module tb_lcd1602_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       buf_we = 1'b0;
  logic [4:0] buf_addr = '0;
  logic [7:0] buf_wdata = '0;
  logic       cg_we = 1'b0;
  logic [5:0] cg_addr = '0;
  logic [4:0] cg_wdata = '0;
  logic       refresh_req = 1'b0;

  logic       busy_o [3];
  logic       en_o   [3];
  logic       rs_o   [3];
  logic       rw_o   [3];
  logic [7:0] data_o [3];

  int         cyc;
  logic [8:0] cap    [3][$];
  int         rise_q [3][$];
  int         fall_q [3][$];
  logic       en_prev [3];
  logic [8:0] exp_q [$];
  logic [7:0] disp_m [32];
  logic [4:0] glyph_m [64];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  lcd1602_driver #(.CLK_DIV(8), .N_CGRAM(0), .REFRESH(0), .CLR_STEPS(4)) dut0 (
    .clk_50M(clk), .rst(rst), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .cg_we(cg_we), .cg_addr(cg_addr), .cg_wdata(cg_wdata), .refresh_req(refresh_req),
    .busy(busy_o[0]), .en(en_o[0]), .RS(rs_o[0]), .RW(rw_o[0]), .data(data_o[0]));

  lcd1602_driver #(.CLK_DIV(8), .N_CGRAM(3), .REFRESH(0), .CLR_STEPS(4)) dut3 (
    .clk_50M(clk), .rst(rst), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .cg_we(cg_we), .cg_addr(cg_addr), .cg_wdata(cg_wdata), .refresh_req(refresh_req),
    .busy(busy_o[1]), .en(en_o[1]), .RS(rs_o[1]), .RW(rw_o[1]), .data(data_o[1]));

  lcd1602_driver #(.CLK_DIV(8), .N_CGRAM(1), .REFRESH(1), .CLR_STEPS(4)) dutr (
    .clk_50M(clk), .rst(rst), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .cg_we(cg_we), .cg_addr(cg_addr), .cg_wdata(cg_wdata), .refresh_req(refresh_req),
    .busy(busy_o[2]), .en(en_o[2]), .RS(rs_o[2]), .RW(rw_o[2]), .data(data_o[2]));

  // cyc equals the number of clock edges since reset release when read at a negedge.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (en_o[i] && !en_prev[i]) begin
        cap[i].push_back({rs_o[i], data_o[i]});
        rise_q[i].push_back(cyc);
      end
      if (!en_o[i] && en_prev[i]) fall_q[i].push_back(cyc);
      en_prev[i] <= en_o[i];
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_caps();
    for (int i = 0; i < 3; i++) begin
      cap[i].delete();
      rise_q[i].delete();
      fall_q[i].delete();
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) disp_m[i] = 8'h20;
    for (int i = 0; i < 64; i++) glyph_m[i] = 5'h00;
  endtask

  task automatic model_glyphs(input int nc);
    exp_q.push_back(9'h040);
    for (int r = 0; r < 8 * nc; r++) exp_q.push_back({1'b1, 3'b000, glyph_m[r]});
  endtask

  task automatic model_init(input int nc);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    if (nc > 0) model_glyphs(nc);
  endtask

  task automatic model_lines();
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, disp_m[i]});
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, disp_m[16 + i]});
  endtask

  // First clock edge with the counter at 0 that sees a refresh request latched at edge e.
  function automatic int exit_edge(input int e);
    return ((e + 7) / 8) * 8 + 1;
  endfunction

  task automatic wait_until(input int k);
    for (int n = 0; n < 5000 && cyc < k; n++) tick();
  endtask

  task automatic pulse_refresh(output int e);
    refresh_req = 1'b1;
    e = cyc + 1;
    tick();
    refresh_req = 1'b0;
  endtask

  task automatic wait_frame(input int inst, input int budget, output bit ok);
    bit seen_hi = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (busy_o[inst]) seen_hi = 1'b1;
      else if (seen_hi) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    tick();
    buf_we = 1'b1; buf_addr = 5'd3; buf_wdata = 8'h41;
    tick();
    buf_we = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++; if (busy_o[i] !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_busy[%0d] got %b expected 1", i, busy_o[i]); end
      vectors++; if (en_o[i] !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_en[%0d] got %b expected 0", i, en_o[i]); end
      vectors++; if (data_o[i] !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_data[%0d] got %h expected 00", i, data_o[i]); end
      vectors++; if (rs_o[i] !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rs[%0d] got %b expected 0", i, rs_o[i]); end
      vectors++; if (rw_o[i] !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rw[%0d] got %b expected 0", i, rw_o[i]); end
    end
  endtask

  task automatic test_init_sequence();
    int t0 = -1, t3 = -1, tr = -1;
    logic [8:0] got;
    clear_caps();
    rst = 1'b0;
    for (int n = 0; n < 900; n++) begin
      tick();
      if (t0 < 0 && !busy_o[0]) t0 = cyc;
      if (t3 < 0 && !busy_o[1]) t3 = cyc;
      if (tr < 0 && !busy_o[2]) tr = cyc;
      if (t0 >= 0 && t3 >= 0 && tr >= 0 && cap[2].size() >= 82) break;
    end
    vectors++; if (t0 !== 328) begin miscompares++; $display("[TB] FAIL init_idle_n0 got cycle %0d expected 328", t0); end
    vectors++; if (t3 !== 528) begin miscompares++; $display("[TB] FAIL init_idle_n3 got cycle %0d expected 528", t3); end
    vectors++; if (tr !== 400) begin miscompares++; $display("[TB] FAIL init_idle_ref got cycle %0d expected 400", tr); end
    for (int inst = 0; inst < 3; inst++) begin
      exp_q.delete();
      model_init(inst == 0 ? 0 : (inst == 1 ? 3 : 1));
      model_lines();
      if (inst == 2) begin model_lines(); exp_q.push_back(9'h080); end
      if (inst != 2) begin
        vectors++;
        if (cap[inst].size() != exp_q.size()) begin
          miscompares++; $display("[TB] FAIL init_len[%0d] got %0d expected %0d", inst, cap[inst].size(), exp_q.size());
        end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (i < cap[inst].size()) ? cap[inst][i] : 9'h1FF;
        vectors++;
        if (got !== exp_q[i]) begin miscompares++; $display("[TB] FAIL init_byte[%0d][%0d] got %h expected %h", inst, i, got, exp_q[i]); end
      end
    end
    for (int i = 0; i < 38 && i < rise_q[0].size() && i < fall_q[0].size(); i++) begin
      int er = (i == 0) ? 2 : (i + 3) * 8 + 2;
      vectors++;
      if (rise_q[0][i] !== er || fall_q[0][i] !== er + 4) begin
        miscompares++; $display("[TB] FAIL init_en_timing[%0d] got rise %0d fall %0d expected %0d %0d", i, rise_q[0][i], fall_q[0][i], er, er + 4);
      end
    end
  endtask

  task automatic test_buffer_refresh();
    int e;
    bit ok0, ok3;
    logic [8:0] got;
    for (int a = 0; a < 32; a++) begin
      if (a == 16 || $urandom_range(0, 3) != 0) begin
        buf_we = 1'b1; buf_addr = 5'(a);
        buf_wdata = (a == 16) ? 8'h41 : 8'($urandom);
        disp_m[a] = buf_wdata;
        tick();
      end
    end
    buf_we = 1'b0;
    clear_caps();
    pulse_refresh(e);
    wait_frame(0, 400, ok0);
    for (int n = 0; n < 20 && busy_o[1]; n++) tick();
    ok3 = !busy_o[1];
    vectors++; if (!(ok0 && ok3)) begin miscompares++; $display("[TB] FAIL refresh_done got %b%b expected 11", ok0, ok3); end
    exp_q.delete();
    model_lines();
    for (int inst = 0; inst < 2; inst++) begin
      vectors++;
      if (cap[inst].size() != 34) begin miscompares++; $display("[TB] FAIL refresh_len[%0d] got %0d expected 34", inst, cap[inst].size()); end
      for (int i = 0; i < 34; i++) begin
        got = (i < cap[inst].size()) ? cap[inst][i] : 9'h1FF;
        vectors++;
        if (got !== exp_q[i]) begin miscompares++; $display("[TB] FAIL refresh_byte[%0d][%0d] got %h expected %h", inst, i, got, exp_q[i]); end
      end
    end
    got = (cap[0].size() > 18) ? cap[0][18] : 9'h1FF;
    vectors++; if (got !== 9'h141) begin miscompares++; $display("[TB] FAIL line2_first got %h expected 141", got); end
    for (int i = 0; i < rise_q[0].size() && i < fall_q[0].size(); i++) begin
      vectors++;
      if (rise_q[0][i] % 8 != 2 || fall_q[0][i] - rise_q[0][i] != 4) begin
        miscompares++; $display("[TB] FAIL en_window[%0d] got rise %0d fall %0d expected rise mod 8 = 2 width 4", i, rise_q[0][i], fall_q[0][i]);
      end
    end
  endtask

  task automatic test_same_cycle_write();
    int e, x;
    bit ok;
    logic [7:0] v5, v6, old6;
    logic [8:0] got;
    v5 = disp_m[5] ^ (8'($urandom_range(1, 255)));
    v6 = disp_m[6] ^ (8'($urandom_range(1, 255)));
    old6 = disp_m[6];
    clear_caps();
    pulse_refresh(e);
    x = exit_edge(e);
    wait_until(x + 47);
    buf_we = 1'b1; buf_addr = 5'd5; buf_wdata = v5;
    tick();
    buf_we = 1'b0;
    disp_m[5] = v5;
    wait_until(x + 56);
    buf_we = 1'b1; buf_addr = 5'd6; buf_wdata = v6;
    tick();
    buf_we = 1'b0;
    exp_q.delete();
    model_lines();
    disp_m[6] = v6;
    wait_frame(0, 400, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL same_cycle_done got 0 expected 1"); end
    for (int inst = 0; inst < 2; inst++) begin
      for (int i = 0; i < 34; i++) begin
        got = (i < cap[inst].size()) ? cap[inst][i] : 9'h1FF;
        vectors++;
        if (got !== exp_q[i]) begin miscompares++; $display("[TB] FAIL same_cycle_byte[%0d][%0d] got %h expected %h", inst, i, got, exp_q[i]); end
      end
    end
    got = (cap[0].size() > 7) ? cap[0][7] : 9'h1FF;
    vectors++; if (got !== {1'b1, old6}) begin miscompares++; $display("[TB] FAIL late_write got %h expected %h", got, {1'b1, old6}); end
  endtask

  task automatic test_glyph();
    bit ok, idle0 = 1'b1;
    logic [8:0] got;
    int a;
    clear_caps();
    for (int n = 0; n < 8 && cyc % 8 != 1; n++) tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin a = 9; cg_wdata = 5'h1F; end
      else begin
        a = $urandom_range(0, 23);
        if (a == 9) a = 10;
        cg_wdata = 5'($urandom);
      end
      cg_we = 1'b1; cg_addr = 6'(a);
      glyph_m[a] = cg_wdata;
      tick();
      if (busy_o[0]) idle0 = 1'b0;
    end
    cg_we = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      tick();
      if (busy_o[0]) idle0 = 1'b0;
      if (!busy_o[1] && cap[1].size() > 0) begin ok = 1'b1; break; end
    end
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL glyph_done got 0 expected 1"); end
    vectors++; if (!idle0 || cap[0].size() != 0) begin miscompares++; $display("[TB] FAIL glyph_n0_idle got bytes %0d expected 0", cap[0].size()); end
    exp_q.delete();
    model_glyphs(3);
    model_lines();
    vectors++; if (cap[1].size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL glyph_len got %0d expected %0d", cap[1].size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap[1].size()) ? cap[1][i] : 9'h1FF;
      vectors++;
      if (got !== exp_q[i]) begin miscompares++; $display("[TB] FAIL glyph_byte[%0d] got %h expected %h", i, got, exp_q[i]); end
    end
    got = (cap[1].size() > 10) ? cap[1][10] : 9'h1FF;
    vectors++; if (got !== 9'h11F) begin miscompares++; $display("[TB] FAIL glyph_row9 got %h expected 11F", got); end
  endtask

  task automatic test_glyph_ignored();
    int e;
    bit stayed = 1'b1, ok;
    logic [8:0] got;
    clear_caps();
    cg_we = 1'b1; cg_addr = 6'd40; cg_wdata = 5'($urandom);
    tick();
    cg_addr = 6'd63; cg_wdata = 5'($urandom);
    tick();
    cg_we = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (busy_o[1]) stayed = 1'b0;
    end
    vectors++; if (!stayed || cap[1].size() != 0) begin miscompares++; $display("[TB] FAIL glyph_oob_idle got bytes %0d expected 0", cap[1].size()); end
    pulse_refresh(e);
    wait_frame(1, 400, ok);
    exp_q.delete();
    model_lines();
    vectors++; if (!ok || cap[1].size() != 34) begin miscompares++; $display("[TB] FAIL glyph_oob_frame got %0d bytes expected 34", cap[1].size()); end
    got = (cap[1].size() > 0) ? cap[1][0] : 9'h1FF;
    vectors++; if (got !== 9'h080) begin miscompares++; $display("[TB] FAIL glyph_oob_first got %h expected 080", got); end
  endtask

  task automatic test_reset_mid();
    int e, x;
    bit ok;
    logic [8:0] got;
    pulse_refresh(e);
    x = exit_edge(e);
    wait_until(x + 34);
    vectors++; if (en_o[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_en_before got %b expected 1", en_o[0]); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (en_o[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_en got %b expected 0", en_o[0]); end
    vectors++; if (data_o[0] !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_rst_data got %h expected 00", data_o[0]); end
    vectors++; if (busy_o[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_rst_busy got %b expected 1", busy_o[0]); end
    tick();
    tick();
    model_reset();
    clear_caps();
    rst = 1'b0;
    wait_frame(1, 700, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL restart_done got 0 expected 1"); end
    got = (rise_q[0].size() > 0) ? 9'(rise_q[0][0]) : 9'h1FF;
    vectors++; if (got !== 9'd2) begin miscompares++; $display("[TB] FAIL restart_first_rise got %0d expected 2", got); end
    for (int inst = 0; inst < 2; inst++) begin
      exp_q.delete();
      model_init(inst == 0 ? 0 : 3);
      model_lines();
      vectors++; if (cap[inst].size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL restart_len[%0d] got %0d expected %0d", inst, cap[inst].size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (i < cap[inst].size()) ? cap[inst][i] : 9'h1FF;
        vectors++;
        if (got !== exp_q[i]) begin miscompares++; $display("[TB] FAIL restart_byte[%0d][%0d] got %h expected %h", inst, i, got, exp_q[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) en_prev[i] = 1'b0;
    test_reset();
    test_init_sequence();
    test_buffer_refresh();
    test_same_cycle_write();
    test_glyph();
    test_glyph_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd1602_driver.md
LCD1602_DRIVER -- requirements
Module: lcd1602_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000: clk_50M cycles per LCD bus step, even and >= 8.
REQ-002 SHALL have parameter N_CGRAM, default 3: number of custom glyphs uploaded, 0..8.
REQ-003 SHALL have parameter REFRESH, default 1: 1 = continuous display rewrite, 0 = rewrite only on request or glyph change.
REQ-004 SHALL have parameter CLR_STEPS, default 4: number of step periods consumed by the clear command.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Port clk_50M  in  1  system clock.
REQ-007 Port rst  in  1  asynchronous reset, active-high.
REQ-008 Port buf_we  in  1  display-buffer write strobe.
REQ-009 Port buf_addr  in  5  buffer index; 0-15 = line 1, 16-31 = line 2.
REQ-010 Port buf_wdata  in  8  character code.
REQ-011 Port cg_we  in  1  glyph-buffer write strobe.
REQ-012 Port cg_addr  in  6  glyph*8 + row.
REQ-013 Port cg_wdata  in  5  glyph row pixels.
REQ-014 Port refresh_req  in  1  single-cycle request to rewrite the display.
REQ-015 Port busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 Port en  out  1  LCD enable.
REQ-017 Port RS  out  1  0 = command, 1 = data.
REQ-018 Port RW  out  1  tied to 0.
REQ-019 Port data  out  8  LCD DB7..DB0.

Function
REQ-020 Step timing SHALL be generated by a counter of 0..CLK_DIV-1; data and RS SHALL change only at count 0; en SHALL be high for counts CLK_DIV/4 through 3*CLK_DIV/4-1 and low otherwise.
REQ-021 FSM states and bytes sent SHALL be, in order:
- INIT_CLR 0x01, RS=0, held for CLR_STEPS steps with en pulsed only in the first.
- INIT_FUNC 0x38.
- INIT_DISP 0x0C.
- INIT_ENTRY 0x06.
- CG_ADDR 0x40.
- CG_DATA N_CGRAM*8 bytes {3'b000, row}, RS=1.
- L1_ADDR 0x80.
- L1_DATA buffer[0..15], RS=1.
- L2_ADDR 0xC0.
- L2_DATA buffer[16..31], RS=1.
- IDLE.
REQ-022 When N_CGRAM=0, CG_ADDR and CG_DATA SHALL be skipped entirely.
REQ-023 Each state byte SHALL occupy exactly one step period (except INIT_CLR); the full initial sequence SHALL take (CLR_STEPS+3+1+8*N_CGRAM+34)*CLK_DIV cycles from reset release to IDLE, or the same minus the CG term when N_CGRAM=0.
REQ-024 Buffer entries SHALL be sampled at the count-0 edge of the step that sends them; a buf_we landing in the same cycle SHALL be visible in that step.
REQ-025 buf_we and cg_we SHALL be accepted in any state with no stall; they carry no handshake.
REQ-026 cg_we with glyph index (cg_addr[5:3]) >= N_CGRAM SHALL be ignored; an accepted cg_we SHALL set cg_dirty.
REQ-027 refresh_req SHALL set refresh_pend in any state; refresh_pend SHALL clear when L1_ADDR is entered.
REQ-028 IDLE exit is evaluated at each count 0:
- cg_dirty -> CG_ADDR, clearing cg_dirty.
- otherwise, refresh_pend or REFRESH=1 -> L1_ADDR.
- otherwise, stay in IDLE with en held low.
REQ-029 RW SHALL be constant 0 and busy SHALL be combinational from state != IDLE.

Reset
REQ-030 While rst is high: state=INIT_CLR, step counter=0, data=0x00, RS=0, en=0, busy=1.
REQ-031 While rst is high: display buffer SHALL be all 0x20, glyph buffer all 0, cg_dirty=0, refresh_pend=0.
REQ-032 Assertion of rst mid-transfer SHALL abort immediately; after release the full initial sequence SHALL restart.

Verification
REQ-033 CLK_DIV=8, N_CGRAM=0, REFRESH=0, reset released -> data sequence 01,38,0C,06,80,20x16,C0,20x16; busy falls after (4+3+34)*8=328 cycles.
REQ-034 CLK_DIV=8, REFRESH=0, in IDLE: write buf_addr=16 with 0x41, then pulse refresh_req -> second-line first data byte 0x41 with RS=1; en high on counts 2..5 of each step.
REQ-035 N_CGRAM=3, in IDLE: cg_we cg_addr=9 data=0x1F -> CG_ADDR 0x40, then 24 data bytes with byte 9 = 0x1F, then line rewrite.
REQ-036 N_CGRAM=3: cg_we with cg_addr=40 -> ignored; cg_dirty stays 0; FSM remains in IDLE.
REQ-037 rst pulsed during L1_DATA -> en=0 and data=0x00 immediately; after release, 0x01 is sent again at the first step.
REQ-038 REFRESH=1 -> after L2_DATA, the next step after IDLE sends 0x80; the rewrite loop repeats indefinitely.
